// File: rtl/ex_ex3_multilane_if.sv
// ex_ex3_multilane_if: bundle of the EX3 stage's operand, memory and status signals.
//   NLANES : lane count; GPR_W : register-ID width; CYC_W : hold counter width.
//   Upstream/control side (master): opUCmd/opUIxt (9 bits per lane), regIdRm,
//     regIdRn1/regValRn1, regIdCn1/regValCn1, regValMulRes, opBraFlush,
//     memDataIn (lane 0), memDataInB (lane 1), memDataOK, exIsHold.
//   Stage side (slave): regIdRn2/regValRn2, regIdCn2/regValCn2, exHold,
//     exFault, exBadOp, exHoldCycles.
interface ex_ex3_multilane_if #(
  parameter int NLANES = 2,
  parameter int GPR_W  = 7,
  parameter int CYC_W  = 4
);
  logic [9*NLANES-1:0]     opUCmd;
  logic [9*NLANES-1:0]     opUIxt;
  logic [1:0]              exHold;
  logic                    exIsHold;
  logic [GPR_W*NLANES-1:0] regIdRm;
  logic [GPR_W*NLANES-1:0] regIdRn1;
  logic [64*NLANES-1:0]    regValRn1;
  logic [GPR_W*NLANES-1:0] regIdCn1;
  logic [64*NLANES-1:0]    regValCn1;
  logic [GPR_W*NLANES-1:0] regIdRn2;
  logic [64*NLANES-1:0]    regValRn2;
  logic [GPR_W*NLANES-1:0] regIdCn2;
  logic [64*NLANES-1:0]    regValCn2;
  logic [64*NLANES-1:0]    regValMulRes;
  logic                    opBraFlush;
  logic [63:0]             memDataIn;
  logic [63:0]             memDataInB;
  logic [1:0]              memDataOK;
  logic                    exFault;
  logic                    exBadOp;
  logic [CYC_W-1:0]        exHoldCycles;

  modport master (
    output opUCmd, opUIxt, exIsHold, regIdRm, regIdRn1, regValRn1,
           regIdCn1, regValCn1, regValMulRes, opBraFlush,
           memDataIn, memDataInB, memDataOK,
    input  exHold, regIdRn2, regValRn2, regIdCn2, regValCn2,
           exFault, exBadOp, exHoldCycles
  );

  modport slave (
    input  opUCmd, opUIxt, exIsHold, regIdRm, regIdRn1, regValRn1,
           regIdCn1, regValCn1, regValMulRes, opBraFlush,
           memDataIn, memDataInB, memDataOK,
    output exHold, regIdRn2, regValRn2, regIdCn2, regValCn2,
           exFault, exBadOp, exHoldCycles
  );
endinterface

// File: rtl/ex_ex3_multilane.sv
// ex_ex3_multilane: third execute stage for NLANES parallel lanes.
//   Forwards each lane's EX2 Rn/Cn destination to writeback, substituting load
//   data (lanes 0/1, size/sign extended) or multiplier results. Generates the
//   pipeline hold for pending memory and multi-cycle MUL3, and keeps sticky
//   fault / bad-op flags for the trap logic.
// Ports:
//   clock, reset : core clock, synchronous active-high reset
//   bus          : ex_ex3_multilane_if.slave (operands, memory status, results,
//                  exHold {held-last, hold-now}, exFault, exBadOp, exHoldCycles)
// Optional (macro JX2_EX3_HOLDSTAT_EN):
//   exStatHeld   : free-running count of cycles with hold-now asserted
//   exStatFlush  : free-running count of cycles with opBraFlush asserted
module ex_ex3_multilane #(
  parameter int NLANES  = 2,
  parameter int GPR_W   = 7,
  parameter int MUL_LAT = 0,
  parameter int CYC_W   = 4
) (
  input  logic clock,
  input  logic reset,
  ex_ex3_multilane_if.slave bus
`ifdef JX2_EX3_HOLDSTAT_EN
  ,
  output logic [31:0] exStatHeld,
  output logic [31:0] exStatFlush
`endif
);

  // Micro-op command codes (low 6 bits of opUCmd).
  localparam logic [5:0] UCMD_NOP      = 6'h00, UCMD_OP_IXS  = 6'h01, UCMD_OP_IXT   = 6'h02,
                         UCMD_MOV_RM   = 6'h03, UCMD_MOV_MR  = 6'h04, UCMD_MOV_IR   = 6'h05,
                         UCMD_LEA_MR   = 6'h06, UCMD_ADDSP   = 6'h07, UCMD_BRA      = 6'h08,
                         UCMD_BSR      = 6'h09, UCMD_JMP     = 6'h0A, UCMD_JSR      = 6'h0B,
                         UCMD_BRA_NB   = 6'h0C, UCMD_ALU3    = 6'h0D, UCMD_UNARY    = 6'h0E,
                         UCMD_ALUW3    = 6'h0F, UCMD_ALUB3   = 6'h10, UCMD_ALUCMP   = 6'h11,
                         UCMD_FLDCX    = 6'h12, UCMD_FSTCX   = 6'h13, UCMD_FCMP     = 6'h14,
                         UCMD_MULW3    = 6'h15, UCMD_SHAD3   = 6'h16, UCMD_SHLD3    = 6'h17,
                         UCMD_SHADQ3   = 6'h18, UCMD_SHLDQ3  = 6'h19, UCMD_CONV_RR  = 6'h1A,
                         UCMD_CONV2_RR = 6'h1B, UCMD_MOV_RC  = 6'h1C, UCMD_MOV_CR   = 6'h1D,
                         UCMD_FPU3     = 6'h1E, UCMD_BLINT   = 6'h1F, UCMD_MUL3     = 6'h20;

  localparam logic [GPR_W-1:0] JX2_GR_ZZR = GPR_W'(7'h3F);
  localparam logic [GPR_W-1:0] JX2_CR_ZZR = GPR_W'(7'h3F);
  localparam logic [CYC_W-1:0] CYC_MAX    = '1;

  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic              held_q, held_d;
  logic              fault_q, fault_d;
  logic              badop_q, badop_d;
  logic [NLANES-1:0] lane_mem, lane_mul, lane_bad;
  logic              mem_hold, mul_wait, mul_hold, hold_now;
  logic              unused_top;

  assign unused_top = ^{bus.exIsHold, bus.memDataIn, bus.memDataInB};

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      // Only lanes 0 and 1 have a memory port.
      localparam bit CAN_MEM = (gi < 2);
      logic [5:0]       ucmd;
      logic [2:0]       sz;
      logic [63:0]      ld_raw, ld_ext, val_rn;
      logic [GPR_W-1:0] id_rn, id_cn;
      logic             unused_bits;

      assign ucmd        = bus.opUCmd[gi*9 +: 6];
      assign sz          = bus.opUIxt[gi*9 +: 3];
      assign unused_bits = ^{bus.opUCmd[gi*9+6 +: 3], bus.opUIxt[gi*9+3 +: 6]};
      assign ld_raw      = (gi == 1) ? bus.memDataInB : bus.memDataIn;

      always_comb begin
        case (sz)
          3'b000:  ld_ext = {{56{ld_raw[7]}},  ld_raw[7:0]};
          3'b001:  ld_ext = {{48{ld_raw[15]}}, ld_raw[15:0]};
          3'b010:  ld_ext = {{32{ld_raw[31]}}, ld_raw[31:0]};
          3'b100:  ld_ext = {56'h0, ld_raw[7:0]};
          3'b101:  ld_ext = {48'h0, ld_raw[15:0]};
          3'b110:  ld_ext = {32'h0, ld_raw[31:0]};
          default: ld_ext = ld_raw;  // x11: full 64-bit load
        endcase
      end

      always_comb begin
        id_rn        = bus.regIdRn1[gi*GPR_W +: GPR_W];
        val_rn       = bus.regValRn1[gi*64 +: 64];
        id_cn        = bus.regIdCn1[gi*GPR_W +: GPR_W];
        lane_mem[gi] = 1'b0;
        lane_mul[gi] = 1'b0;
        lane_bad[gi] = 1'b0;
        // A flushed lane behaves as NOP: no hold, no bad-op.
        if (!bus.opBraFlush) begin
          case (ucmd)
            UCMD_MOV_MR: begin
              if (CAN_MEM) begin
                id_rn        = bus.regIdRm[gi*GPR_W +: GPR_W];
                val_rn       = ld_ext;
                lane_mem[gi] = 1'b1;
              end else begin
                lane_bad[gi] = 1'b1;
              end
            end
            UCMD_MOV_RM: begin
              if (CAN_MEM) lane_mem[gi] = 1'b1;
              else         lane_bad[gi] = 1'b1;
            end
            UCMD_MUL3: begin
              id_rn        = bus.regIdRm[gi*GPR_W +: GPR_W];
              val_rn       = bus.regValMulRes[gi*64 +: 64];
              lane_mul[gi] = 1'b1;
            end
            UCMD_NOP, UCMD_OP_IXS, UCMD_OP_IXT, UCMD_MOV_IR, UCMD_LEA_MR,
            UCMD_ADDSP, UCMD_BRA, UCMD_BSR, UCMD_JMP, UCMD_JSR, UCMD_BRA_NB,
            UCMD_ALU3, UCMD_UNARY, UCMD_ALUW3, UCMD_ALUB3, UCMD_ALUCMP,
            UCMD_FLDCX, UCMD_FSTCX, UCMD_FCMP, UCMD_MULW3, UCMD_SHAD3,
            UCMD_SHLD3, UCMD_SHADQ3, UCMD_SHLDQ3, UCMD_CONV_RR, UCMD_CONV2_RR,
            UCMD_MOV_RC, UCMD_MOV_CR, UCMD_FPU3, UCMD_BLINT: begin
            end
            default: lane_bad[gi] = 1'b1;
          endcase
        end else begin
          // Flush discards the write, even one substituted by load/MUL.
          id_rn = JX2_GR_ZZR;
          id_cn = JX2_CR_ZZR;
        end
      end

      assign bus.regIdRn2[gi*GPR_W +: GPR_W]  = id_rn;
      assign bus.regValRn2[gi*64 +: 64]       = val_rn;
      assign bus.regIdCn2[gi*GPR_W +: GPR_W]  = id_cn;
      assign bus.regValCn2[gi*64 +: 64]       = bus.regValCn1[gi*64 +: 64];
    end

    // The hold counter doubles as the MUL3 latency counter.
    if (MUL_LAT == 0) begin : g_nomul
      assign mul_wait = 1'b0;
    end else begin : g_mul
      assign mul_wait = (cnt_q < CYC_W'(MUL_LAT));
    end
  endgenerate

  // memDataOK is shared, so both loading lanes wait on the same status.
  assign mem_hold = (|lane_mem) & bus.memDataOK[1];
  assign mul_hold = (|lane_mul) & mul_wait;
  assign hold_now = mem_hold | mul_hold;

  always_comb begin
    held_d  = hold_now;
    cnt_d   = hold_now ? ((cnt_q == CYC_MAX) ? cnt_q : cnt_q + 1'b1) : '0;
    fault_d = fault_q | (mem_hold & bus.memDataOK[0]);
    badop_d = badop_q | (|lane_bad);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      held_q  <= 1'b0;
      fault_q <= 1'b0;
      badop_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      fault_q <= fault_d;
      badop_q <= badop_d;
    end
  end

  assign bus.exHold       = {held_q, hold_now};
  assign bus.exHoldCycles = cnt_q;
  assign bus.exFault      = fault_q;
  assign bus.exBadOp      = badop_q;

`ifdef JX2_EX3_HOLDSTAT_EN
  logic [31:0] stat_held_q, stat_flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_held_q  <= '0;
      stat_flush_q <= '0;
    end else begin
      stat_held_q  <= stat_held_q + {31'h0, hold_now};
      stat_flush_q <= stat_flush_q + {31'h0, bus.opBraFlush};
    end
  end

  assign exStatHeld  = stat_held_q;
  assign exStatFlush = stat_flush_q;
`endif

endmodule

// File: tb/tb_ex_ex3_multilane.sv
// tb_ex_ex3_multilane: scoreboard bench for ex_ex3_multilane (3 lanes, MUL_LAT=2).
// Each cycle the stimulus is applied just after the rising edge, the expected
// values are queued, and at the falling edge the queue is drained against the DUT.
module tb_ex_ex3_multilane;
  localparam int NL = 3, GW = 7, CW = 4;
  localparam logic [5:0] C_NOP = 6'h00, C_MOV_RM = 6'h03, C_MOV_MR = 6'h04,
                         C_MUL3 = 6'h20, C_BAD = 6'h3F;
  localparam logic [63:0] ZZR = 64'h3F;
  localparam int K_IDRN = 0, K_VALRN = 1, K_IDCN = 2, K_HOLD = 3,
                 K_CYC = 4, K_FAULT = 5, K_BAD = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          q_kind[$];
  int          q_lane[$];
  string       q_tag[$];
  logic [63:0] q_exp[$];

  always #5 clk = ~clk;

  ex_ex3_multilane_if #(.NLANES(NL), .GPR_W(GW), .CYC_W(CW)) bus ();

`ifdef JX2_EX3_HOLDSTAT_EN
  logic [31:0] stat_held, stat_flush;
`endif

  ex_ex3_multilane #(.NLANES(NL), .GPR_W(GW), .MUL_LAT(2), .CYC_W(CW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
`ifdef JX2_EX3_HOLDSTAT_EN
    ,
    .exStatHeld  (stat_held),
    .exStatFlush (stat_flush)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int kind, input int lane);
    case (kind)
      K_IDRN:  return 64'(bus.regIdRn2[lane*GW +: GW]);
      K_VALRN: return bus.regValRn2[lane*64 +: 64];
      K_IDCN:  return 64'(bus.regIdCn2[lane*GW +: GW]);
      K_HOLD:  return 64'(bus.exHold);
      K_CYC:   return 64'(bus.exHoldCycles);
      K_FAULT: return 64'(bus.exFault);
      default: return 64'(bus.exBadOp);
    endcase
  endfunction

  task automatic expect_v(input int kind, input int lane, input string tag, input logic [63:0] v);
    q_kind.push_back(kind);
    q_lane.push_back(lane);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  // Drain the scoreboard at the falling edge, then step to the next drive point.
  task automatic cycle_check();
    int k, l;
    string t;
    logic [63:0] e;
    @(negedge clk);
    while (q_kind.size() > 0) begin
      k = q_kind.pop_front();
      l = q_lane.pop_front();
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      check_val(t, observe(k, l), e);
      $display("[TB] %s lane%0d exp=%h", t, l, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int lane, input logic [5:0] cmd, input logic [2:0] ixt);
    bus.opUCmd[lane*9 +: 9] = {3'b000, cmd};
    bus.opUIxt[lane*9 +: 9] = {6'b000000, ixt};
  endtask

  task automatic set_idle();
    for (int i = 0; i < NL; i++) begin
      set_op(i, C_NOP, 3'b000);
      bus.regIdRm[i*GW +: GW]     = GW'(30 + i);
      bus.regIdRn1[i*GW +: GW]    = GW'(10 + i);
      bus.regValRn1[i*64 +: 64]   = 64'h1000 + 64'(i);
      bus.regIdCn1[i*GW +: GW]    = GW'(20 + i);
      bus.regValCn1[i*64 +: 64]   = 64'h2000 + 64'(i);
      bus.regValMulRes[i*64 +: 64] = 64'h3000 + 64'(i);
    end
    bus.opBraFlush = 1'b0;
    bus.exIsHold   = 1'b0;
    bus.memDataIn  = '0;
    bus.memDataInB = '0;
    bus.memDataOK  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  t_sz  [8];
    logic [63:0] t_dat [8];
    logic [63:0] t_exp [8];
    t_sz[0] = 3'b000; t_dat[0] = 64'h80;                   t_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    t_sz[1] = 3'b001; t_dat[1] = 64'h0000_0000_0001_8001;  t_exp[1] = 64'hFFFF_FFFF_FFFF_8001;
    t_sz[2] = 3'b010; t_dat[2] = 64'h0000_0001_8000_0000;  t_exp[2] = 64'hFFFF_FFFF_8000_0000;
    t_sz[3] = 3'b100; t_dat[3] = 64'hFFFF_FFFF_FFFF_FF80;  t_exp[3] = 64'h80;
    t_sz[4] = 3'b101; t_dat[4] = 64'hFFFF_FFFF_FFFF_8001;  t_exp[4] = 64'h8001;
    t_sz[5] = 3'b110; t_dat[5] = 64'hFFFF_FFFF_8000_0000;  t_exp[5] = 64'h8000_0000;
    t_sz[6] = 3'b011; t_dat[6] = 64'h8123_4567_89AB_CDEF;  t_exp[6] = 64'h8123_4567_89AB_CDEF;
    t_sz[7] = 3'b111; t_dat[7] = 64'hFEDC_BA98_7654_3210;  t_exp[7] = 64'hFEDC_BA98_7654_3210;

    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    expect_v(K_CYC, 0, "rst_cyc", 0);
    expect_v(K_HOLD, 0, "rst_hold", 0);
    expect_v(K_FAULT, 0, "rst_fault", 0);
    expect_v(K_BAD, 0, "rst_bad", 0);
    expect_v(K_IDRN, 1, "fwd_id", 11);
    expect_v(K_VALRN, 2, "fwd_val", 64'h1002);
    cycle_check();
    rst = 1'b0;

    // Unknown ucmd on a flushed lane is ignored; IDs forced to ZZR.
    set_op(2, C_BAD, 3'b000);
    bus.opBraFlush = 1'b1;
    for (int i = 0; i < NL; i++) begin
      expect_v(K_IDRN, i, "flush_rn", ZZR);
      expect_v(K_IDCN, i, "flush_cn", ZZR);
    end
    cycle_check();
    set_idle();
    expect_v(K_BAD, 0, "bad_flushed", 0);
    cycle_check();
    set_op(2, C_BAD, 3'b000);
    expect_v(K_BAD, 0, "bad_pre", 0);
    cycle_check();
    set_idle();
    expect_v(K_BAD, 0, "bad_set", 1);
    cycle_check();

    // Lane-0 loads, every size code, memory ready.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_op(0, C_MOV_MR, t_sz[i]);
      bus.regIdRm[0 +: GW] = 7'd5;
      bus.memDataIn = t_dat[i];
      expect_v(K_IDRN, 0, "ld_id", 5);
      expect_v(K_VALRN, 0, "ld_val", t_exp[i]);
      expect_v(K_HOLD, 0, "ld_hold", 0);
      expect_v(K_IDCN, 0, "ld_cn", 20);
      cycle_check();
    end

    // Lane-1 load held for three cycles.
    set_idle();
    set_op(1, C_MOV_MR, 3'b101);
    bus.regIdRm[GW +: GW] = 7'd6;
    bus.memDataInB = 64'h1234_8001;
    bus.memDataOK = 2'b10;
    for (int k = 0; k < 3; k++) begin
      expect_v(K_HOLD, 1, "l1_hold", {62'h0, (k > 0), 1'b1});
      expect_v(K_CYC, 1, "l1_cyc", 64'(k));
      cycle_check();
    end
    bus.memDataOK = 2'b00;
    expect_v(K_HOLD, 1, "l1_rel", 2'b10);
    expect_v(K_IDRN, 1, "l1_id", 6);
    expect_v(K_VALRN, 1, "l1_val", 64'h8001);
    cycle_check();
    set_idle();
    expect_v(K_HOLD, 1, "l1_idle", 0);
    expect_v(K_CYC, 1, "l1_cyc0", 0);
    cycle_check();

    // MUL3 with MUL_LAT=2.
    set_op(0, C_MUL3, 3'b000);
    bus.regIdRm[0 +: GW] = 7'd9;
    bus.regValMulRes[0 +: 64] = 64'd42;
    expect_v(K_HOLD, 0, "mul_h0", 2'b01);
    cycle_check();
    expect_v(K_HOLD, 0, "mul_h1", 2'b11);
    expect_v(K_CYC, 0, "mul_c1", 1);
    cycle_check();
    expect_v(K_HOLD, 0, "mul_rel", 2'b10);
    expect_v(K_IDRN, 0, "mul_id", 9);
    expect_v(K_VALRN, 0, "mul_val", 42);
    cycle_check();
    set_idle();
    expect_v(K_CYC, 0, "mul_cyc0", 0);
    cycle_check();

    // Dual loads share memDataOK; 01 also counts as ready.
    set_op(0, C_MOV_MR, 3'b111);
    set_op(1, C_MOV_MR, 3'b111);
    bus.memDataIn  = 64'hAAAA_0000_0000_0001;
    bus.memDataInB = 64'hBBBB_0000_0000_0002;
    bus.memDataOK  = 2'b10;
    expect_v(K_HOLD, 0, "dual_hold", 2'b01);
    cycle_check();
    bus.memDataOK = 2'b01;
    expect_v(K_HOLD, 0, "dual_rel", 2'b10);
    expect_v(K_VALRN, 0, "dual_v0", 64'hAAAA_0000_0000_0001);
    expect_v(K_VALRN, 1, "dual_v1", 64'hBBBB_0000_0000_0002);
    expect_v(K_IDRN, 1, "dual_id1", 31);
    cycle_check();

    // Flush with a pending load: no hold.
    set_idle();
    set_op(0, C_MOV_MR, 3'b000);
    bus.memDataOK = 2'b10;
    bus.opBraFlush = 1'b1;
    expect_v(K_HOLD, 0, "flush_hold", 0);
    expect_v(K_IDRN, 0, "flush_ld_rn", ZZR);
    expect_v(K_IDCN, 2, "flush_ld_cn", ZZR);
    cycle_check();

    // Store holds, forwarding unchanged; counter saturates.
    set_idle();
    set_op(0, C_MOV_RM, 3'b000);
    bus.memDataOK = 2'b10;
    for (int k = 0; k < 18; k++) begin
      expect_v(K_CYC, 0, "sat_cyc", 64'((k > 15) ? 15 : k));
      expect_v(K_IDRN, 0, "st_id", 10);
      cycle_check();
    end
    rst = 1'b1;
    expect_v(K_HOLD, 0, "pre_rst_hold", 2'b11);
    cycle_check();
    rst = 1'b0;
    set_idle();
    expect_v(K_CYC, 0, "rst_hold_cyc", 0);
    expect_v(K_HOLD, 0, "rst_hold_h", 0);
    expect_v(K_BAD, 0, "rst_bad_clr", 0);
    cycle_check();

    // Memory fault is sticky until reset.
    set_op(0, C_MOV_MR, 3'b000);
    bus.memDataOK = 2'b11;
    expect_v(K_FAULT, 0, "flt_pre", 0);
    expect_v(K_HOLD, 0, "flt_hold", 2'b01);
    cycle_check();
    set_idle();
    for (int k = 0; k < 11; k++) begin
      expect_v(K_FAULT, 0, "flt_sticky", 1);
      cycle_check();
    end
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    expect_v(K_FAULT, 0, "flt_clr", 0);
    cycle_check();

    // Memory op on lane 2 is unhandled and does not hold.
    set_op(2, C_MOV_RM, 3'b000);
    bus.memDataOK = 2'b10;
    expect_v(K_HOLD, 0, "l2_hold", 0);
    cycle_check();
    set_idle();
    expect_v(K_BAD, 0, "l2_bad", 1);
    cycle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
